// File: rtl/fakeram64x7_ctrl.sv
// Request sequencer for the fakeram45_64x7 macro: zero-fills the array after reset, then forwards
// valid/ready requests to the macro and buffers read data in a 2-entry response FIFO.
module fakeram64x7_ctrl #(
  parameter int unsigned       ADDR_W     = 6,
  parameter int unsigned       DATA_W     = 7,
  parameter int unsigned       DEPTH      = 64,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_w_mask,
  output logic [DATA_W-1:0] ram_wd,
  input  logic [DATA_W-1:0] ram_rd
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, wr_ptr_q;
  logic [DATA_W-1:0] fifo_q [2];

  logic       accept, push, pop;
  logic [2:0] occ;

  assign init_done = (state_q == StRun) && !rst;
  assign rsp_valid = (count_q != 2'd0) && !rst;
  assign rsp_rdata = rsp_valid ? fifo_q[rd_ptr_q] : '0;

  assign pop  = rsp_valid && rsp_ready;
  assign push = inflight_q;

  // Occupancy after this cycle's pop, counting the read whose data lands next cycle.
  assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign req_ready = init_done && (occ < 3'd2);
  assign accept    = req_valid && req_ready;

  assign inflight_d = accept && !req_we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ram_ce     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = '0;
    ram_w_mask = '0;
    ram_wd     = '0;
    unique case (state_q)
      StInit: begin
        ram_ce     = 1'b1;
        ram_we     = 1'b1;
        ram_addr   = cnt_q;
        ram_w_mask = '1;
        ram_wd     = INIT_VALUE;
        cnt_d      = cnt_q + ADDR_W'(1);
        if (cnt_q == LastAddr) state_d = StRun;
      end
      StRun: begin
        if (accept) begin
          ram_ce     = 1'b1;
          ram_we     = req_we;
          ram_addr   = req_addr;
          ram_w_mask = req_wmask;
          ram_wd     = req_wdata;
        end
      end
    endcase
    if (rst) begin
      state_d    = StInit;
      cnt_d      = '0;
      ram_ce     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_w_mask = '0;
      ram_wd     = '0;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      wr_ptr_q   <= wr_ptr_q ^ push;
    end
  end

  // Macro read data is only valid for one cycle, so capture it unconditionally on push.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr_q] <= ram_rd;
  end

endmodule

// File: tb/tb_fakeram64x7_ctrl.sv
// Directed bench for fakeram64x7_ctrl with a behavioural macro model and a response scoreboard.
module tb_fakeram64x7_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [5:0] req_addr = '0;
  logic [6:0] req_wdata = '0;
  logic [6:0] req_wmask = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [6:0] rsp_rdata;
  logic       init_done;
  logic       ram_ce, ram_we;
  logic [5:0] ram_addr;
  logic [6:0] ram_w_mask, ram_wd, ram_rd;

  int passed = 0;
  int total  = 0;
  int rsp_cnt = 0;
  logic [6:0] sb[$];
  logic [6:0] ref_mem [64];

  // Behavioural macro: masked write, one-cycle read latency, output not held.
  logic [6:0] mem [64];
  logic [6:0] rd_q, garb_q;
  logic       rd_vld_q = 1'b0;
  assign ram_rd = rd_vld_q ? rd_q : garb_q;

  fakeram64x7_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_w_mask(ram_w_mask),
    .ram_wd(ram_wd), .ram_rd(ram_rd)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 7'($urandom);
      ref_mem[i] = 7'h00;
    end
  end

  always @(posedge clk) begin
    garb_q   <= 7'($urandom);
    rd_vld_q <= ram_ce && !ram_we;
    if (ram_ce && ram_we) mem[ram_addr] <= (mem[ram_addr] & ~ram_w_mask) | (ram_wd & ram_w_mask);
    if (ram_ce && !ram_we) rd_q <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: reads push expected data on acceptance, responses pop and compare.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        rsp_cnt++;
        if (sb.size() == 0) check("rsp_extra", 32'(sb.size()), 32'd1);
        else check("rsp_data", {25'd0, rsp_rdata}, {25'd0, sb.pop_front()});
      end
      if (req_valid && req_ready) begin
        if (req_we) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
        else sb.push_back(ref_mem[req_addr]);
      end
    end
  end

  task automatic send(input logic we, input logic [5:0] a, input logic [6:0] d,
                      input logic [6:0] m, output int stalls);
    stalls = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    @(negedge clk);
    while (!req_ready && stalls < 50) begin
      @(negedge clk);
      stalls++;
    end
    if (!req_ready) check("send_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
  endtask

  task automatic check_rst_outs();
    check("rst_outs", {req_ready, rsp_valid, init_done, ram_ce, ram_we, ram_addr, ram_w_mask,
                       ram_wd, rsp_rdata}, 32'd0);
  endtask

  // Called at posedge+1 right after rst is released (cycle 0).
  task automatic check_sweep();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("init_pins", {10'd0, ram_ce, ram_we, ram_addr, ram_w_mask, ram_wd},
            {10'd0, 1'b1, 1'b1, 6'(i), 7'h7f, 7'h00});
      check("init_busy", {29'd0, init_done, req_ready, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    check("init_done", {30'd0, init_done, req_ready}, 32'd3);
    @(posedge clk); #1;
  endtask

  function automatic logic [6:0] pat(input int i);
    return 7'(i * 5 + 3);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st, c0;
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst_outs();
    @(posedge clk); #1;
    rst = 1'b0;
    check_sweep();

    // Read the last swept address
    send(1'b0, 6'd63, 7'h00, 7'h00, st);
    check("rd63_stall", 32'(st), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Masked write then read with exact latency
    send(1'b1, 6'd5, 7'h55, 7'h7f, st);
    send(1'b1, 6'd5, 7'h2a, 7'h0f, st);
    send(1'b0, 6'd5, 7'h00, 7'h00, st);
    @(negedge clk);
    check("mask_lat_n1", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("mask_lat_n2", {24'd0, rsp_valid, rsp_rdata}, {24'd0, 1'b1, 7'h5a});
    @(posedge clk); #1;

    // Write-then-read on consecutive cycles
    send(1'b1, 6'd9, 7'h33, 7'h7f, st);
    send(1'b0, 6'd9, 7'h00, 7'h00, st);
    check("raw_stall", 32'(st), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("raw_data", {24'd0, rsp_valid, rsp_rdata}, {24'd0, 1'b1, 7'h33});
    @(posedge clk); #1;

    // Fill a distinct pattern, then stream 16 reads
    for (int i = 0; i < 16; i++) send(1'b1, 6'(i), pat(i), 7'h7f, st);
    c0 = rsp_cnt;
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 6'(i), 7'h00, 7'h00, st);
      check("stream_ready", 32'(st), 32'd0);
    end
    check("stream_cnt14", 32'(rsp_cnt - c0), 32'd14);
    repeat (2) @(posedge clk);
    #1;
    check("stream_cnt16", 32'(rsp_cnt - c0), 32'd16);

    // Backpressure: two reads fit, the rest stall until a pop
    rsp_ready = 1'b0;
    c0 = rsp_cnt;
    send(1'b0, 6'd1, 7'h00, 7'h00, st);
    send(1'b0, 6'd2, 7'h00, 7'h00, st);
    check("bp_two_acc", 32'(st), 32'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_stalled", {23'd0, req_ready, rsp_valid, rsp_rdata}, {23'd0, 1'b0, 1'b1, pat(1)});
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_reassert", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    send(1'b0, 6'd4, 7'h00, 7'h00, st);
    repeat (4) @(posedge clk);
    #1;
    check("bp_rsp_cnt", 32'(rsp_cnt - c0), 32'd4);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-sweep at init cycle 30
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_rst_outs();
    @(posedge clk); #1;
    rst = 1'b0;
    check_sweep();

    // Reset with two responses queued
    rsp_ready = 1'b0;
    send(1'b0, 6'd2, 7'h00, 7'h00, st);
    send(1'b0, 6'd3, 7'h00, 7'h00, st);
    @(posedge clk); #1;
    @(negedge clk);
    check("q2_full", {30'd0, rsp_valid, req_ready}, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < 64; i++) ref_mem[i] = 7'h00;
    @(negedge clk);
    check_rst_outs();
    @(posedge clk); #1;
    rst = 1'b0;
    check_sweep();
    rsp_ready = 1'b1;
    c0 = rsp_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_rsp", 32'(rsp_cnt - c0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
